// File: rtl/marcher_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : marcher_dispatcher_if
// Description : Job, result and framebuffer-write bundle between the
//               dispatcher, its ray-march cores and bram_manager.
// Revision    : 1.0 - initial release
// ============================================================================
interface marcher_dispatcher_if #(
    parameter int NUM_CORES = 4,
    parameter int H_BITS    = 9,
    parameter int V_BITS    = 8,
    parameter int ADDR_BITS = 17
);
    logic [NUM_CORES-1:0]        job_valid_out;
    logic [NUM_CORES-1:0]        job_ready_in;
    logic [H_BITS-1:0]           job_hcount_out;
    logic [V_BITS-1:0]           job_vcount_out;
    logic [NUM_CORES-1:0]        res_valid_in;
    logic [NUM_CORES-1:0]        res_ready_out;
    logic [NUM_CORES*H_BITS-1:0] res_hcount_in;
    logic [NUM_CORES*V_BITS-1:0] res_vcount_in;
    logic [NUM_CORES*4-1:0]      res_color_in;
    logic                        write_enable_out;
    logic [ADDR_BITS-1:0]        write_addr_out;
    logic [3:0]                  write_data_out;
    logic                        frame_start_out;
    logic                        swap_buffers_out;
    logic                        busy_out;

    modport master (
        output job_valid_out, job_hcount_out, job_vcount_out, res_ready_out,
               write_enable_out, write_addr_out, write_data_out,
               frame_start_out, swap_buffers_out, busy_out,
        input  job_ready_in, res_valid_in, res_hcount_in, res_vcount_in,
               res_color_in
    );

    modport slave (
        input  job_valid_out, job_hcount_out, job_vcount_out, res_ready_out,
               write_enable_out, write_addr_out, write_data_out,
               frame_start_out, swap_buffers_out, busy_out,
        output job_ready_in, res_valid_in, res_hcount_in, res_vcount_in,
               res_color_in
    );
endinterface
`default_nettype wire

// File: rtl/marcher_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : marcher_dispatcher
// Description : Round-robin frame job scheduler over NUM_CORES ray marchers
//               with result arbitration onto a single framebuffer write port.
// Revision    : 1.0 - initial release
// ============================================================================
module marcher_dispatcher #(
    parameter int NUM_CORES      = 4,
    parameter int DISPLAY_WIDTH  = 320,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int H_BITS         = 9,
    parameter int V_BITS         = 8,
    parameter int ADDR_BITS      = 17
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    marcher_dispatcher_if.master m_bus
);
    localparam int c_PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int c_PIX   = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int c_OUT_W = $clog2(c_PIX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_SWAP     = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [H_BITS-1:0]    r_h;
    logic [V_BITS-1:0]    r_v;
    logic [c_OUT_W-1:0]   r_outstanding;
    logic [c_PTR_W-1:0]   r_job_ptr;
    logic [c_PTR_W-1:0]   r_res_ptr;
    logic                 r_drop;
    logic                 r_we;
    logic [ADDR_BITS-1:0] r_addr;
    logic [3:0]           r_data;

    logic [c_PTR_W:0]     w_job_pick;
    logic [c_PTR_W:0]     w_res_pick;
    logic [c_PTR_W-1:0]   w_job_idx;
    logic [c_PTR_W-1:0]   w_res_idx;
    logic                 w_job_go;
    logic                 w_res_go;
    logic                 w_last;
    logic                 w_row_end;
    logic [H_BITS-1:0]    w_res_h;
    logic [V_BITS-1:0]    w_res_v;
    logic [3:0]           w_res_color;
    logic [ADDR_BITS-1:0] w_res_addr;

    // MSB flags a hit; low bits give the first requester at or after ptr.
    function automatic logic [c_PTR_W:0] f_rr_pick(
        input logic [NUM_CORES-1:0] req,
        input logic [c_PTR_W-1:0]   ptr
    );
        logic [c_PTR_W:0] res;
        int               idx;
        res = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CORES)
                idx = idx - NUM_CORES;
            if (req[idx])
                res = {1'b1, c_PTR_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (int'(p) == NUM_CORES - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_job_pick  = f_rr_pick(m_bus.job_ready_in, r_job_ptr);
        w_res_pick  = f_rr_pick(m_bus.res_valid_in, r_res_ptr);
        w_job_idx   = w_job_pick[c_PTR_W-1:0];
        w_res_idx   = w_res_pick[c_PTR_W-1:0];
        w_job_go    = !rst_in && (r_state == S_DISPATCH) && w_job_pick[c_PTR_W];
        w_res_go    = !rst_in && w_res_pick[c_PTR_W];
        w_row_end   = (r_h == H_BITS'(DISPLAY_WIDTH - 1));
        w_last      = w_row_end && (r_v == V_BITS'(DISPLAY_HEIGHT - 1));
        w_res_h     = m_bus.res_hcount_in[int'(w_res_idx)*H_BITS +: H_BITS];
        w_res_v     = m_bus.res_vcount_in[int'(w_res_idx)*V_BITS +: V_BITS];
        w_res_color = m_bus.res_color_in[int'(w_res_idx)*4 +: 4];
        w_res_addr  = ADDR_BITS'(w_res_v) * ADDR_BITS'(DISPLAY_WIDTH)
                    + ADDR_BITS'(w_res_h);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // The final write is already registered once outstanding reaches zero,
    // so swap may follow it directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = S_START;
            S_START:    w_state_nxt = S_DISPATCH;
            S_DISPATCH: if (w_job_go && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN:    if (r_outstanding == '0 && !w_res_go) w_state_nxt = S_SWAP;
            S_SWAP:     w_state_nxt = S_START;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_bus.job_valid_out    = w_job_go ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << w_job_idx) : '0;
        m_bus.res_ready_out    = w_res_go ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << w_res_idx) : '0;
        m_bus.job_hcount_out   = r_h;
        m_bus.job_vcount_out   = r_v;
        m_bus.write_enable_out = r_we;
        m_bus.write_addr_out   = r_addr;
        m_bus.write_data_out   = r_data;
        m_bus.frame_start_out  = (r_state == S_START);
        m_bus.swap_buffers_out = (r_state == S_SWAP);
        m_bus.busy_out         = (r_state != S_IDLE);
    end

    // r_drop swallows results of jobs abandoned by a reset until the next frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_h           <= '0;
            r_v           <= '0;
            r_outstanding <= '0;
            r_job_ptr     <= '0;
            r_res_ptr     <= '0;
            r_drop        <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
        end else begin
            r_we <= w_res_go && !r_drop;
            if (w_res_go) begin
                r_res_ptr <= f_inc(w_res_idx);
                r_addr    <= w_res_addr;
                r_data    <= w_res_color;
            end
            if (w_job_go) begin
                r_job_ptr <= f_inc(w_job_idx);
                if (w_row_end) begin
                    r_h <= '0;
                    r_v <= r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
            if (r_state == S_SWAP) begin
                r_h <= '0;
                r_v <= '0;
            end
            if (r_state == S_START)
                r_drop <= 1'b0;
            case ({w_job_go, w_res_go && !r_drop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && w_res_go && !r_drop)
            assert (r_outstanding != '0);
    end
endmodule
`default_nettype wire

// File: tb/tb_marcher_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_marcher_dispatcher
// Description : Randomised core models driving marcher_dispatcher, checked
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_marcher_dispatcher;
    localparam int NC   = 2;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HB   = 9;
    localparam int VB   = 8;
    localparam int AB   = 17;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    marcher_dispatcher_if #(.NUM_CORES(NC), .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)) bus ();

    marcher_dispatcher #(
        .NUM_CORES(NC), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
        .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .m_bus  (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Core models (stimulus side)
    bit         c_busy [NC];
    bit         c_has  [NC];
    int         c_cnt  [NC];
    int         c_h    [NC];
    int         c_v    [NC];
    logic [3:0] c_col  [NC];
    int         lat_lo [NC];
    int         lat_hi [NC];
    int         rdy_pct;
    logic [NC-1:0] rdy_mask;

    // Reference model
    int   m_jp, m_rp, m_issued, m_nwritten, m_since_rst, m_wr_addr;
    bit   m_disp, m_drop, m_wr_pend, m_start_due, m_swap_due;
    logic [3:0] m_wr_col;
    bit   m_written [NPIX];
    int   dut_swaps;

    function automatic int pick(input logic [NC-1:0] req, input int ptr);
        for (int k = 0; k < NC; k++)
            if (req[(ptr + k) % NC]) return (ptr + k) % NC;
        return -1;
    endfunction

    task automatic drive_inputs(input bit allow_ready);
        logic [NC-1:0] rdy, vld;
        for (int i = 0; i < NC; i++) begin
            rdy[i] = allow_ready && !c_busy[i] && rdy_mask[i] && ($urandom_range(99) < rdy_pct);
            vld[i] = c_has[i];
            bus.res_hcount_in[i*HB +: HB] = HB'(c_h[i]);
            bus.res_vcount_in[i*VB +: VB] = VB'(c_v[i]);
            bus.res_color_in[i*4 +: 4]    = c_col[i];
        end
        bus.job_ready_in = rdy;
        bus.res_valid_in = vld;
    endtask

    task automatic cycle();
        logic [NC-1:0] exp_jv, exp_rr, rdy, vld;
        int  jsel, rsel;
        bit  start_now, swap_now, final_write;
        @(negedge clk);
        drive_inputs(1'b1);
        rdy = bus.job_ready_in;
        vld = bus.res_valid_in;
        #1;
        chk("frame_start", bus.frame_start_out, m_start_due);
        chk("swap", bus.swap_buffers_out, m_swap_due);
        chk("busy", bus.busy_out, m_since_rst != 0);
        if (m_since_rst == 0) begin
            chk("rst_hcount", bus.job_hcount_out, 0);
            chk("rst_vcount", bus.job_vcount_out, 0);
        end
        if (bus.swap_buffers_out) dut_swaps++;

        jsel = m_disp ? pick(rdy, m_jp) : -1;
        exp_jv = '0;
        if (jsel >= 0) exp_jv[jsel] = 1'b1;
        chk("job_valid", bus.job_valid_out, exp_jv);
        if (jsel >= 0) begin
            chk("job_h", bus.job_hcount_out, m_issued % W);
            chk("job_v", bus.job_vcount_out, m_issued / W);
        end

        rsel = pick(vld, m_rp);
        exp_rr = '0;
        if (rsel >= 0) exp_rr[rsel] = 1'b1;
        chk("res_ready", bus.res_ready_out, exp_rr);

        final_write = 1'b0;
        chk("wr_en", bus.write_enable_out, m_wr_pend);
        if (m_wr_pend) begin
            chk("wr_addr", bus.write_addr_out, m_wr_addr);
            chk("wr_data", bus.write_data_out, m_wr_col);
            chk("dup_pixel", m_written[m_wr_addr], 0);
            m_written[m_wr_addr] = 1'b1;
            m_nwritten++;
            final_write = (m_nwritten == NPIX);
        end

        m_wr_pend = (rsel >= 0) && !m_drop;
        if (rsel >= 0) begin
            m_wr_addr = c_v[rsel] * W + c_h[rsel];
            m_wr_col  = c_col[rsel];
            m_rp      = (rsel + 1) % NC;
        end
        if (jsel >= 0) begin
            m_jp = (jsel + 1) % NC;
            m_issued++;
            if (m_issued == NPIX) m_disp = 1'b0;
        end
        start_now   = m_start_due;
        swap_now    = m_swap_due;
        m_start_due = swap_now || (m_since_rst == 0);
        m_swap_due  = final_write;
        if (start_now) begin
            m_disp     = 1'b1;
            m_drop     = 1'b0;
            m_issued   = 0;
            m_nwritten = 0;
            for (int p = 0; p < NPIX; p++) m_written[p] = 1'b0;
        end
        m_since_rst++;

        for (int i = 0; i < NC; i++) begin
            if (bus.res_ready_out[i] && c_has[i]) begin
                c_has[i]  = 1'b0;
                c_busy[i] = 1'b0;
            end else if (c_busy[i] && !c_has[i]) begin
                if (c_cnt[i] == 0) c_has[i] = 1'b1;
                else c_cnt[i]--;
            end
            if (bus.job_valid_out[i] && rdy[i]) begin
                c_busy[i] = 1'b1;
                c_h[i]    = int'(bus.job_hcount_out);
                c_v[i]    = int'(bus.job_vcount_out);
                c_col[i]  = 4'($urandom);
                c_cnt[i]  = $urandom_range(lat_hi[i], lat_lo[i]);
            end
        end
    endtask

    // Abandoned jobs return their results at once so they land in the drop window.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NC; i++)
            if (c_busy[i]) c_has[i] = 1'b1;
        drive_inputs(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_jp = 0; m_rp = 0; m_issued = 0; m_nwritten = 0; m_since_rst = 0;
        m_disp = 1'b0; m_drop = 1'b1; m_wr_pend = 1'b0;
        m_start_due = 1'b0; m_swap_due = 1'b0;
    endtask

    task automatic set_cfg(input logic [NC-1:0] mask, input int pct,
                           input int l0lo, input int l0hi, input int l1lo, input int l1hi);
        rdy_mask  = mask;
        rdy_pct   = pct;
        lat_lo[0] = l0lo; lat_hi[0] = l0hi;
        lat_lo[1] = l1lo; lat_hi[1] = l1hi;
    endtask

    task automatic run_frames(input string tag, input int nframes);
        int target = dut_swaps + nframes;
        int cyc = 0;
        while (dut_swaps < target && cyc < 3000) begin
            cycle();
            cyc++;
        end
        chk(tag, dut_swaps >= target, 1);
    endtask

    initial begin
        bus.job_ready_in  = '0;
        bus.res_valid_in  = '0;
        bus.res_hcount_in = '0;
        bus.res_vcount_in = '0;
        bus.res_color_in  = '0;
        dut_swaps = 0;
        set_cfg(2'b11, 100, 1, 1, 1, 1);
        do_reset();
        run_frames("frames_all_ready", 2);

        set_cfg(2'b10, 100, 0, 2, 0, 2);
        run_frames("frames_core1_only", 1);

        set_cfg(2'b11, 100, 0, 0, 0, 0);
        run_frames("frames_fast", 2);

        set_cfg(2'b11, 100, 20, 20, 0, 0);
        run_frames("frames_core0_slow", 2);

        set_cfg(2'b11, 60, 0, 6, 0, 6);
        run_frames("frames_random", 6);

        set_cfg(2'b11, 100, 8, 8, 8, 8);
        begin
            int cyc = 0;
            while (!(m_disp && m_issued == 6) && cyc < 500) begin
                cycle();
                cyc++;
            end
            chk("reach_pixel_2_1", m_disp && m_issued == 6, 1);
        end
        do_reset();
        set_cfg(2'b11, 70, 0, 4, 0, 4);
        run_frames("frames_after_reset", 2);

        for (int r = 0; r < 3; r++) begin
            set_cfg(2'($urandom_range(3, 1)), $urandom_range(90, 30),
                    0, $urandom_range(10), 0, $urandom_range(10));
            run_frames("frames_mixed", 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/marcher_dispatcher.md
Name: marcher_dispatcher

Overview:
- Schedules one frame of per-pixel ray-march jobs across NUM_CORES parallel ray_marcher cores.
- Arbitrates the cores' finished pixels onto the single write port of bram_manager.
- Issues the buffer-swap pulse only after every pixel of the frame has been written.
- Sits between user_control/ray marcher cores and bram_manager, and replaces the direct single-marcher hookup.

Parameters:
- NUM_CORES, 4, number of ray marcher cores (2..8).
- DISPLAY_WIDTH, 320, pixels per row.
- DISPLAY_HEIGHT, 240, rows per frame.
- H_BITS, 9, hcount width.
- V_BITS, 8, vcount width.
- ADDR_BITS, 17, framebuffer address width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- job_valid_out  output  NUM_CORES  one-hot or zero; job offered to core i.
- job_ready_in  input  NUM_CORES  core i can accept a job.
- job_hcount_out  output  H_BITS  pixel x of the offered job, shared by all cores.
- job_vcount_out  output  V_BITS  pixel y of the offered job, shared by all cores.
- res_valid_in  input  NUM_CORES  core i holds a finished pixel.
- res_ready_out  output  NUM_CORES  one-hot or zero; result of core i consumed this cycle.
- res_hcount_in  input  NUM_CORES*H_BITS  result x; core i occupies slice [i*H_BITS +: H_BITS].
- res_vcount_in  input  NUM_CORES*V_BITS  result y, packed the same way.
- res_color_in  input  NUM_CORES*4  result colour, packed the same way.
- write_enable_out  output  1  framebuffer write strobe.
- write_addr_out  output  ADDR_BITS  vcount*DISPLAY_WIDTH + hcount.
- write_data_out  output  4  colour.
- frame_start_out  output  1  1-cycle pulse; cores latch pos/dir/fractal config.
- swap_buffers_out  output  1  1-cycle pulse to bram_manager.
- busy_out  output  1  high in any state except IDLE.

Behaviour:
- Clock and reset: clk_in is the single clock. rst_in is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - Pixel counters (h,v) = 0.
  - Outstanding count = 0.
  - Job and result round-robin pointers = 0.
  - Reset mid-frame abandons all jobs. Results arriving before the next frame_start_out are accepted and dropped: res_ready_out is asserted, write_enable_out stays 0.
- FSM:
  - IDLE → START after one cycle.
  - START: frame_start_out=1 for 1 cycle → DISPATCH.
  - DISPATCH:
    - Offers pixel (h,v).
    - Selected core = first i at or after the job pointer (cyclic) with job_ready_in[i]=1. job_valid_out drives only that bit. This is combinational from job_ready_in and state.
    - Transfer occurs when the selected bit is set. On transfer:
      - Pointer ← selected+1 (mod NUM_CORES).
      - h increments. At h=DISPLAY_WIDTH-1, h←0 and v increments.
      - Outstanding +1.
      - Max one job per cycle.
    - Transfer of (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1) → DRAIN.
  - DRAIN: no jobs offered. → SWAP when outstanding==0 and the write pipeline is empty.
  - SWAP: swap_buffers_out=1 for 1 cycle; counters cleared → START. Frames run back-to-back.
- Result arbitration (active in every state):
  - Grant = first i at or after the result pointer with res_valid_in[i]=1.
  - res_ready_out[i]=1 combinationally; the pointer advances past the granted core.
  - Next cycle, registered: write_enable_out=1, write_addr_out=res_v*DISPLAY_WIDTH+res_h, write_data_out=colour. Latency 1 cycle.
  - Outstanding -1 on each grant.
- Simultaneous job transfer and result grant leave outstanding unchanged.
- Outstanding width is clog2(W*H+1). It never underflows: a grant at outstanding 0 is a protocol error, asserted in simulation and saturating in RTL.
- Results may complete out of order. Address is computed from the returned coordinates, never from issue order.

Test Plan (W=4, H=2, NUM_CORES=2 unless noted):
- Reset, then all job_ready_in=1 and cores returning in 3 cycles:
  - frame_start_out pulses at cycle 1.
  - Jobs alternate core0/core1 with (h,v)=(0,0),(1,0),(2,0),(3,0),(0,1)…(3,1).
  - 8 writes with addr 0..7.
  - swap_buffers_out pulses exactly once, after the 8th write.
- Only core1 ready: all 8 jobs go to core1; job_valid_out[0] never asserted.
- Both cores res_valid_in=1 every cycle:
  - Grants alternate 0,1,0,1.
  - No result is lost.
  - write_enable_out is high on consecutive cycles.
- Core0 result delayed 20 cycles, core1 fast:
  - Writes occur out of order with correct addresses.
  - State stays DRAIN until core0's last result; swap follows one cycle after that write.
- Same-cycle job transfer and result grant, with outstanding at 1: outstanding stays 1; no premature swap.
- rst_in asserted during DISPATCH at pixel (2,1):
  - Next cycle all outputs are 0 and counters are 0.
  - A pending res_valid_in is consumed without a write.
  - A fresh frame_start_out follows.
